tmds_channel_decoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 41 ++++
 rtl/tmds_word_aligner.sv | 44 ++++
 rtl/tmds_channel_decoder.sv | 137 +++++++++++++
 tb/tb_tmds_channel_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, FSM state type, and the
// token-match and DVI symbol-decode helpers used by the channel decoder.
package tmds_pkg;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } tmds_state_t;

  function automatic logic is_ctrl(input logic [9:0] w);
    return (w == TOK_00) || (w == TOK_01) || (w == TOK_10) || (w == TOK_11);
  endfunction

  function automatic logic [1:0] ctrl_code(input logic [9:0] w);
    logic [1:0] c;
    c = 2'b00;
    if (w == TOK_01) c = 2'b01;
    if (w == TOK_10) c = 2'b10;
    if (w == TOK_11) c = 2'b11;
    return c;
  endfunction

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
  function automatic logic [7:0] dvi_decode(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] q;
    d    = w[9] ? ~w[7:0] : w[7:0];
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Word aligner: keeps the previous deserialized word and selects a 10-bit
// symbol from the 20-bit {current, previous} window at the chosen offset.
module tmds_word_aligner
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  input  logic [3:0] bit_offset,
  output logic [9:0] aligned_r,
  output logic       v1
);

  logic [9:0]  prev;
  logic [19:0] window;
  logic [9:0]  aligned_nxt;

  assign window = {sym_in, prev};

  // Offset mux over the ten legal bit positions.
  always_comb begin
    aligned_nxt = window[9:0];
    for (int i = 0; i < 10; i++) begin
      if (bit_offset == 4'(i)) aligned_nxt = window[i +: 10];
    end
  end

  // Stage 1 register: capture the aligned symbol and its qualifier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev      <= '0;
      aligned_r <= '0;
      v1        <= 1'b0;
    end else begin
      v1 <= sym_valid;
      if (sym_valid) begin
        prev      <= sym_in;
        aligned_r <= aligned_nxt;
      end
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: searches all ten bit offsets for a run of
// control tokens, holds lock while tokens keep arriving, and decodes each
// aligned symbol to pixel data or a control code.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_RUN     = 16,
  parameter int SEARCH_WIN   = 2048,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  input  logic       resync,
  output logic       out_valid,
  output logic       out_de,
  output logic [1:0] out_ctrl,
  output logic [7:0] out_data,
  output logic       locked,
  output logic       lock_lost,
  output logic [3:0] bit_offset
);

  localparam int RUN_W = $clog2(LOCK_RUN);
  localparam int WIN_W = $clog2(SEARCH_WIN);
  localparam int TO_W  = $clog2(LOSS_TIMEOUT);

  logic [9:0]       aligned_r;
  logic             v1;
  logic             tok;
  tmds_state_t      state;
  logic [RUN_W-1:0] run_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             discard;

  tmds_word_aligner u_aligner (
    .clk        (clk),
    .reset      (reset),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .bit_offset (bit_offset),
    .aligned_r  (aligned_r),
    .v1         (v1)
  );

  assign tok = is_ctrl(aligned_r);

  // Alignment FSM: token-run search per offset, timeout-based loss of lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SEARCH;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
      bit_offset <= '0;
      run_cnt    <= '0;
      win_cnt    <= '0;
      to_cnt     <= '0;
      discard    <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (resync) begin
        state   <= ST_SEARCH;
        locked  <= 1'b0;
        run_cnt <= '0;
        win_cnt <= '0;
        to_cnt  <= '0;
        discard <= 1'b0;
      end else if (v1) begin
        case (state)
          ST_SEARCH: begin
            if (discard) begin
              // This symbol was sliced with the offset we just left.
              discard <= 1'b0;
            end else if (tok && (run_cnt == RUN_W'(LOCK_RUN - 1))) begin
              state   <= ST_LOCKED;
              locked  <= 1'b1;
              run_cnt <= '0;
              win_cnt <= '0;
            end else if (win_cnt == WIN_W'(SEARCH_WIN - 1)) begin
              bit_offset <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
              run_cnt    <= '0;
              win_cnt    <= '0;
              discard    <= 1'b1;
            end else begin
              run_cnt <= tok ? run_cnt + 1'b1 : '0;
              win_cnt <= win_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (tok) begin
              to_cnt <= '0;
            end else if (to_cnt == TO_W'(LOSS_TIMEOUT - 1)) begin
              state     <= ST_SEARCH;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              to_cnt    <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

  // Stage 2 register: decode the aligned symbol; outputs are quiet unless locked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_de    <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (state != ST_LOCKED) begin
      out_valid <= 1'b0;
      out_de    <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (v1) begin
      out_valid <= 1'b1;
      if (tok) begin
        out_de   <= 1'b0;
        out_ctrl <= ctrl_code(aligned_r);
        out_data <= '0;
      end else begin
        out_de   <= 1'b1;
        out_ctrl <= '0;
        out_data <= dvi_decode(aligned_r);
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: table of per-cycle vectors for
// lock and decode at offset 0, plus hand sequences for timeout, resync,
// skewed-stream search and mid-stream reset.
module tb_tmds_channel_decoder;

  localparam logic [9:0] T  = 10'h354;
  localparam logic [9:0] C1 = 10'h0AB;
  localparam logic [9:0] C2 = 10'h154;
  localparam logic [9:0] C3 = 10'h2AB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sym_in = '0;
  logic       sym_valid = 1'b0;
  logic       resync = 1'b0;
  logic       out_valid;
  logic       out_de;
  logic [1:0] out_ctrl;
  logic [7:0] out_data;
  logic       locked;
  logic       lock_lost;
  logic [3:0] bit_offset;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [9:0] sym;
    logic       vld;
    logic       ev;
    logic       ede;
    logic [1:0] ectrl;
    logic [7:0] edata;
    logic       elock;
  } vec_t;

  vec_t       tbl [32];
  logic [9:0] dw [7];
  logic [7:0] dx [7];

  always #5 clk = ~clk;

  tmds_channel_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .resync     (resync),
    .out_valid  (out_valid),
    .out_de     (out_de),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .locked     (locked),
    .lock_lost  (lock_lost),
    .bit_offset (bit_offset)
  );

  function automatic vec_t mk(input logic [9:0] s, input logic v, input logic ev,
                              input logic ede, input logic [1:0] ec,
                              input logic [7:0] ed, input logic el);
    vec_t r;
    r.sym = s; r.vld = v; r.ev = ev; r.ede = ede;
    r.ectrl = ec; r.edata = ed; r.elock = el;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step(input logic [9:0] s, input logic v);
    sym_in    = s;
    sym_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Source word n of the skewed-stream test.
  function automatic logic [9:0] src(input int n);
    if (n >= 6300 && n < 6314) return dw[(n - 6300) % 7];
    return T;
  endfunction

  // Deserializer output when the word boundary is 7 bits late.
  function automatic logic [9:0] skewed(input int n);
    logic [9:0] a;
    logic [9:0] b;
    a = src(n);
    b = src(n + 1);
    return {b[6:0], a[9:7]};
  endfunction

  initial begin
    int pulses;
    int pulse_at;

    dw[0] = 10'h133; dx[0] = 8'h55;
    dw[1] = 10'h200; dx[1] = 8'hFF;
    dw[2] = 10'h100; dx[2] = 8'h00;
    dw[3] = 10'h3FF; dx[3] = 8'h00;
    dw[4] = 10'h2AA; dx[4] = 8'h01;
    dw[5] = 10'h1FF; dx[5] = 8'h01;
    dw[6] = 10'h0F0; dx[6] = 8'hEE;

    for (int i = 0; i < 17; i++) tbl[i] = mk(T, 1, 0, 0, 2'd0, 8'h00, 0);
    tbl[17] = mk(T,      1, 0, 0, 2'd0, 8'h00, 1);
    tbl[18] = mk(T,      1, 1, 0, 2'd0, 8'h00, 1);
    tbl[19] = mk(T,      1, 1, 0, 2'd0, 8'h00, 1);
    tbl[20] = mk(10'h133,1, 1, 0, 2'd0, 8'h00, 1);
    tbl[21] = mk(10'h200,1, 1, 0, 2'd0, 8'h00, 1);
    tbl[22] = mk(T,      1, 1, 1, 2'd0, 8'h55, 1);
    tbl[23] = mk(T,      1, 1, 1, 2'd0, 8'hFF, 1);
    tbl[24] = mk(C1,     1, 1, 0, 2'd0, 8'h00, 1);
    tbl[25] = mk(C2,     1, 1, 0, 2'd0, 8'h00, 1);
    tbl[26] = mk(C3,     1, 1, 0, 2'd1, 8'h00, 1);
    tbl[27] = mk(10'h133,1, 1, 0, 2'd2, 8'h00, 1);
    tbl[28] = mk(T,      1, 1, 0, 2'd3, 8'h00, 1);
    tbl[29] = mk(10'h000,0, 1, 1, 2'd0, 8'h55, 1);
    tbl[30] = mk(T,      1, 0, 1, 2'd0, 8'h55, 1);
    tbl[31] = mk(T,      1, 1, 0, 2'd0, 8'h00, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_de", 32'(out_de), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_offset", 32'(bit_offset), 0);
    reset = 1'b0;

    // Lock at offset 0, data decode, all four control codes, hold on gap
    for (int i = 0; i < 32; i++) begin
      step(tbl[i].sym, tbl[i].vld);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_de", i), 32'(out_de), 32'(tbl[i].ede));
      chk($sformatf("tbl%0d_ctrl", i), 32'(out_ctrl), 32'(tbl[i].ectrl));
      chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].edata));
      chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].elock));
      chk($sformatf("tbl%0d_offset", i), 32'(bit_offset), 0);
      chk($sformatf("tbl%0d_lost", i), 32'(lock_lost), 0);
    end

    // Loss of lock after 4096 data symbols
    pulses = 0;
    pulse_at = -1;
    for (int k = 1; k <= 4110; k++) begin
      step(10'h133, 1);
      if (lock_lost) begin
        pulses++;
        if (pulse_at < 0) pulse_at = k;
      end
      if (k == 4097) chk("t4_locked_before", 32'(locked), 1);
      if (k == 4098) begin
        chk("t4_locked_drop", 32'(locked), 0);
        chk("t4_last_valid", 32'(out_valid), 1);
        chk("t4_last_data", 32'(out_data), 32'h55);
      end
      if (k == 4099) chk("t4_valid_stop", 32'(out_valid), 0);
    end
    chk("t4_pulses", 32'(pulses), 1);
    chk("t4_pulse_at", 32'(pulse_at), 4098);
    chk("t4_offset", 32'(bit_offset), 0);
    for (int k = 0; k < 25; k++) step(T, 1);
    chk("t4_relock", 32'(locked), 1);
    chk("t4_relock_valid", 32'(out_valid), 1);

    // Resync while locked
    resync = 1'b1;
    step(T, 1);
    resync = 1'b0;
    chk("t5_locked", 32'(locked), 0);
    chk("t5_no_lost", 32'(lock_lost), 0);
    step(T, 1);
    chk("t5_valid_off", 32'(out_valid), 0);
    chk("t5_no_lost2", 32'(lock_lost), 0);
    for (int k = 0; k < 20; k++) step(T, 1);
    chk("t5_relock", 32'(locked), 1);
    chk("t5_offset", 32'(bit_offset), 0);
    chk("t5_ctrl_valid", 32'(out_valid), 1);

    // Skewed stream: search steps through offsets 0..3, then decodes
    reset = 1'b1;
    sym_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 1; n <= 6312; n++) begin
      step(skewed(n), 1);
      if (n == 2040) chk("t2_off_a", 32'(bit_offset), 0);
      if (n == 2060) chk("t2_off_b", 32'(bit_offset), 1);
      if (n == 4090) chk("t2_off_c", 32'(bit_offset), 1);
      if (n == 4110) chk("t2_off_d", 32'(bit_offset), 2);
      if (n == 6140) chk("t2_off_e", 32'(bit_offset), 2);
      if (n == 6160) begin
        chk("t2_off_f", 32'(bit_offset), 3);
        chk("t2_not_yet", 32'(locked), 0);
      end
      if (n == 6200) begin
        chk("t2_locked", 32'(locked), 1);
        chk("t2_off_lock", 32'(bit_offset), 3);
      end
      if (n >= 6301) begin
        chk($sformatf("t2_valid%0d", n), 32'(out_valid), 1);
        chk($sformatf("t2_de%0d", n), 32'(out_de), 1);
        chk($sformatf("t2_data%0d", n), 32'(out_data), 32'(dx[(n - 1 - 6300) % 7]));
      end
    end

    // Asynchronous reset in the middle of data
    reset = 1'b1;
    sym_valid = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_de", 32'(out_de), 0);
    chk("t6_data", 32'(out_data), 0);
    chk("t6_locked", 32'(locked), 0);
    chk("t6_offset", 32'(bit_offset), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 17; k++) step(T, 1);
    chk("t6_not_yet", 32'(locked), 0);
    step(T, 1);
    chk("t6_relock", 32'(locked), 1);
    step(T, 1);
    chk("t6_valid_after", 32'(out_valid), 1);
    chk("t6_ctrl_after", 32'(out_ctrl), 0);
    chk("t6_offset_after", 32'(bit_offset), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
